// File: rtl/comparator_nbit_serial.sv
`default_nettype none
// ============================================================================
//  Module   : comparator_nbit_serial
//  Purpose  : MSB-first serial magnitude comparator, DIGIT bits per clock,
//             signed/unsigned, one-hot {gt,lt,eq} result with start/busy/done.
//             Define COMPARATOR_SERIAL_EARLY_EXIT_EN to finish on the first
//             differing digit instead of always running N digits.
//  Revision : 1.0  initial release
// ============================================================================
module comparator_nbit_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic [2:0]       y
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
        $error("comparator_nbit_serial: WIDTH must be >= 1 and a multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sa_q, sb_q;
    logic [WIDTH-1:0] sa_d, sb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       res_q, res_d;
    logic             busy_q;
    logic             done_q;
    logic [2:0]       y_q;

    logic [WIDTH-1:0] w_flip;
    logic [DIGIT-1:0] w_dig_a, w_dig_b;
    logic             w_gt, w_lt;
    logic             w_last;
    logic             w_finish;

    // Flipping both MSBs maps two's complement order onto unsigned order.
    assign w_flip  = WIDTH'(signed_mode) << (WIDTH - 1);

    assign w_dig_a = sa_q[WIDTH-1 -: DIGIT];
    assign w_dig_b = sb_q[WIDTH-1 -: DIGIT];
    assign w_gt    = (w_dig_a > w_dig_b);
    assign w_lt    = (w_dig_a < w_dig_b);

    assign sa_d    = sa_q << DIGIT;
    assign sb_d    = sb_q << DIGIT;
    assign cnt_d   = cnt_q - CW'(1);
    assign res_d   = (res_q != 2'b00) ? res_q : {w_gt, w_lt};
    assign w_last  = (cnt_q == CW'(1));

`ifdef COMPARATOR_SERIAL_EARLY_EXIT_EN
    assign w_finish = w_last | (res_d != 2'b00);
`else
    assign w_finish = w_last;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
            res_q   <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            y_q     <= 3'b000;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sa_q    <= a ^ w_flip;
                        sb_q    <= b ^ w_flip;
                        cnt_q   <= CW'(N);
                        res_q   <= 2'b00;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    sa_q  <= sa_d;
                    sb_q  <= sb_d;
                    cnt_q <= cnt_d;
                    res_q <= res_d;
                    if (w_finish) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        y_q     <= (res_d == 2'b00) ? 3'b001 : {res_d, 1'b0};
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign y    = y_q;

endmodule
`default_nettype wire

// File: tb/tb_comparator_nbit_serial.sv
`default_nettype none
// ============================================================================
//  Module   : tb_comparator_nbit_serial
//  Purpose  : Directed + random bench for comparator_nbit_serial at
//             (8,1), (8,4) and (1,1) against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_comparator_nbit_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_s [3];
    logic [7:0] a_s [3];
    logic [7:0] b_s [3];
    logic       sm_s [3];

    logic       bz0, bz1, bz2;
    logic       dn0, dn1, dn2;
    logic [2:0] y0, y1, y2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    comparator_nbit_serial #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .start(start_s[0]), .a(a_s[0]), .b(b_s[0]),
        .signed_mode(sm_s[0]), .busy(bz0), .done(dn0), .y(y0));

    comparator_nbit_serial #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst), .start(start_s[1]), .a(a_s[1]), .b(b_s[1]),
        .signed_mode(sm_s[1]), .busy(bz1), .done(dn1), .y(y1));

    comparator_nbit_serial #(.WIDTH(1), .DIGIT(1)) u_w1 (
        .clk(clk), .rst(rst), .start(start_s[2]), .a(a_s[2][0:0]), .b(b_s[2][0:0]),
        .signed_mode(sm_s[2]), .busy(bz2), .done(dn2), .y(y2));

    function automatic logic gb(input int sel);
        return (sel == 0) ? bz0 : (sel == 1) ? bz1 : bz2;
    endfunction

    function automatic logic gd(input int sel);
        return (sel == 0) ? dn0 : (sel == 1) ? dn1 : dn2;
    endfunction

    function automatic logic [2:0] gy(input int sel);
        return (sel == 0) ? y0 : (sel == 1) ? y1 : y2;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: numeric compare of the operand values, latency from digit scan.
    task automatic model(input int sel, input logic [7:0] av, input logic [7:0] bv,
                         input logic sm, output logic [2:0] ey, output int el);
        int w, d, n, va, vb, da, db;
        w  = (sel == 2) ? 1 : 8;
        d  = (sel == 1) ? 4 : 1;
        n  = w / d;
        va = int'(av) & ((1 << w) - 1);
        vb = int'(bv) & ((1 << w) - 1);
        if (sm && va >= (1 << (w - 1))) va -= (1 << w);
        if (sm && vb >= (1 << (w - 1))) vb -= (1 << w);
        ey = (va > vb) ? 3'b100 : (va < vb) ? 3'b010 : 3'b001;
        el = n;
`ifdef COMPARATOR_SERIAL_EARLY_EXIT_EN
        for (int j = n - 1; j >= 0; j--) begin
            da = (int'(av) >> (w - (j + 1) * d)) & ((1 << d) - 1);
            db = (int'(bv) >> (w - (j + 1) * d)) & ((1 << d) - 1);
            if (da != db) el = j + 1;
        end
`else
        da = 0;
        db = 0;
`endif
    endtask

    task automatic run_op(input int sel, input logic [7:0] av, input logic [7:0] bv,
                          input logic sm, input int restart_at, input bit poke_done,
                          input string tag);
        logic [2:0] ey, prev_y;
        int         el, lat, busy_cnt;
        bit         held;
        model(sel, av, bv, sm, ey, el);
        @(negedge clk);
        a_s[sel] = av; b_s[sel] = bv; sm_s[sel] = sm; start_s[sel] = 1'b1;
        prev_y = gy(sel);
        @(posedge clk); #1;
        start_s[sel] = 1'b0;
        a_s[sel] = 8'($urandom); b_s[sel] = 8'($urandom); sm_s[sel] = 1'($urandom);
        lat = 0; busy_cnt = 0; held = 1'b1;
        while (!gd(sel) && lat < 40) begin
            if (gb(sel)) busy_cnt++;
            if (gy(sel) !== prev_y) held = 1'b0;
            if (lat == restart_at) begin
                start_s[sel] = 1'b1; a_s[sel] = 8'hFF; b_s[sel] = 8'h00; sm_s[sel] = 1'b0;
            end
            @(posedge clk); #1;
            start_s[sel] = 1'b0;
            lat++;
        end
        chk({tag, "_latency"}, lat, el);
        chk({tag, "_y"}, int'(gy(sel)), int'(ey));
        chk({tag, "_busy_cycles"}, busy_cnt, el);
        chk({tag, "_y_held"}, int'(held), 1);
        if (poke_done) start_s[sel] = 1'b1;
        @(posedge clk); #1;
        start_s[sel] = 1'b0;
        chk({tag, "_done_pulse"}, int'(gd(sel)), 0);
        chk({tag, "_idle_busy"}, int'(gb(sel)), 0);
    endtask

    initial begin
        logic [7:0] ra, rb;
        int         rs;
        bit         saw_done;
        for (int i = 0; i < 3; i++) begin
            start_s[i] = 1'b0; a_s[i] = 8'h00; b_s[i] = 8'h00; sm_s[i] = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset_y", int'(gy(i)), 0);
            chk("reset_busy", int'(gb(i)), 0);
            chk("reset_done", int'(gd(i)), 0);
        end
        rst = 1'b0;

        run_op(0, 8'h5A, 8'h5A, 1'b0, -1, 1'b0, "eq_5a");
        run_op(0, 8'h80, 8'h01, 1'b0, -1, 1'b0, "u_80_01");
        run_op(0, 8'h80, 8'h01, 1'b1, -1, 1'b0, "s_80_01");
        run_op(1, 8'h37, 8'h3A, 1'b0, -1, 1'b0, "d4_37_3a");
        run_op(0, 8'h80, 8'h7F, 1'b0, -1, 1'b1, "u_80_7f_pokedone");
        run_op(0, 8'h10, 8'h20, 1'b0, 1, 1'b0, "restart_ignored");

        // Abort a following operation with reset mid-RUN.
        @(negedge clk);
        a_s[0] = 8'h33; b_s[0] = 8'h33; sm_s[0] = 1'b0; start_s[0] = 1'b1;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrun_rst_busy", int'(bz0), 0);
        chk("midrun_rst_done", int'(dn0), 0);
        chk("midrun_rst_y", int'(y0), 0);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (dn0 || bz0) saw_done = 1'b1;
        end
        chk("midrun_rst_no_done", int'(saw_done), 0);

        for (int i = 0; i < 8; i++)
            run_op(2, 8'(i & 1), 8'((i >> 1) & 1), 1'(i >> 2), -1, 1'b0, "w1");

        for (int i = 0; i < 30; i++) begin
            rs = $urandom_range(0, 1);
            ra = 8'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
            run_op(rs, ra, rb, 1'($urandom), -1, 1'b0, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
